// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of CPU stores draining to data memory in program order.
// Optional store-to-load forwarding is compiled in when STORE_BUFFER_FWD_EN is defined.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [AW-1:0]            dataadr,
  input  logic [DW-1:0]            writedata,
  output logic                     stall,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  input  logic [AW-1:0]            rd_addr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [AW-1:0] adr_mem [DEPTH];
  logic [DW-1:0] dat_mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_reg == FULL);
  assign empty = (count_reg == '0);
  // A pop in the same cycle never frees room for a push: full blocks the store outright.
  assign push  = memwrite & ~full;
  assign pop   = ~empty & mem_ready;

  assign stall     = memwrite & full;
  assign mem_we    = ~empty;
  assign mem_addr  = empty ? '0 : adr_mem[rd_ptr_reg];
  assign mem_wdata = empty ? '0 : dat_mem[rd_ptr_reg];
  assign count     = count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage is never reset; every consumer is masked by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wr_ptr_reg] <= dataadr;
      dat_mem[wr_ptr_reg] <= writedata;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0]    age [DEPTH];
  logic [DEPTH-1:0] match;
  logic [PW-1:0]    best_age;
  logic             unused_rd_lo;

  assign unused_rd_lo = ^rd_addr[1:0];

  // age is the distance from the head; an entry is live when its age is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign age[gi]   = PW'(gi) - rd_ptr_reg;
    assign match[gi] = ({1'b0, age[gi]} < count_reg) &&
                       (adr_mem[gi][AW-1:2] == rd_addr[AW-1:2]);
  end

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    best_age = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k] && (!fwd_hit || age[k] > best_age)) begin
        fwd_hit  = 1'b1;
        best_age = age[k];
        fwd_data = dat_mem[k];
      end
    end
  end
`else
  logic unused_rd;

  assign unused_rd = ^rd_addr;
  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard monitor plus per-scenario directed tests.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [AW-1:0] rd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  int exp_n;
  logic [AW+DW-1:0] q[$];
  logic [AW+DW-1:0] exp_e;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .rd_addr(rd_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs change only just after posedge, so negedge sees a settled cycle.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
    end else begin
      exp_n = q.size();
      n_checks++;
      if (count !== CW'(exp_n)) begin
        n_fail++;
        $display("FAIL sb_count actual=%0d expected=%0d", count, exp_n);
      end
      n_checks++;
      if (mem_we !== (exp_n != 0)) begin
        n_fail++;
        $display("FAIL sb_mem_we actual=%0b expected=%0b", mem_we, exp_n != 0);
      end
      n_checks++;
      if (stall !== (memwrite && exp_n == DEPTH)) begin
        n_fail++;
        $display("FAIL sb_stall actual=%0b expected=%0b", stall, memwrite && exp_n == DEPTH);
      end
      if (mem_ready && exp_n != 0) begin
        exp_e = q.pop_front();
        pops++;
        n_checks++;
        if ({mem_addr, mem_wdata} !== exp_e) begin
          n_fail++;
          $display("FAIL sb_drain actual=%h/%h expected=%h/%h",
                   mem_addr, mem_wdata, exp_e[AW+DW-1:DW], exp_e[DW-1:0]);
        end else begin
          $display("pop  addr=%h data=%h", mem_addr, mem_wdata);
        end
      end
      if (memwrite && exp_n < DEPTH) begin
        q.push_back({dataadr, writedata});
        $display("push addr=%h data=%h", dataadr, writedata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; memwrite = 1'b1; dataadr = 84; writedata = 7;
    mem_ready = 1'b1; rd_addr = 84;
    #2;
    n_checks++; if (count !== 0)    begin n_fail++; $display("FAIL reset_count actual=%0d expected=0", count); end
    n_checks++; if (mem_we !== 0)   begin n_fail++; $display("FAIL reset_mem_we actual=%0b expected=0", mem_we); end
    n_checks++; if (stall !== 0)    begin n_fail++; $display("FAIL reset_stall actual=%0b expected=0", stall); end
    n_checks++; if (fwd_hit !== 0)  begin n_fail++; $display("FAIL reset_fwd_hit actual=%0b expected=0", fwd_hit); end
    n_checks++; if (fwd_data !== 0) begin n_fail++; $display("FAIL reset_fwd_data actual=%h expected=0", fwd_data); end
    tick();
    n_checks++; if (count !== 0)    begin n_fail++; $display("FAIL reset_hold_count actual=%0d expected=0", count); end
    memwrite = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    mem_ready = 1'b1; memwrite = 1'b1; dataadr = 84; writedata = 7;
    tick();
    memwrite = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1)     begin n_fail++; $display("FAIL single_mem_we actual=%0b expected=1", mem_we); end
    n_checks++; if (mem_addr !== 84)  begin n_fail++; $display("FAIL single_addr actual=%0d expected=84", mem_addr); end
    n_checks++; if (mem_wdata !== 7)  begin n_fail++; $display("FAIL single_data actual=%0d expected=7", mem_wdata); end
    n_checks++; if (count !== 1)      begin n_fail++; $display("FAIL single_count actual=%0d expected=1", count); end
    tick();
    n_checks++; if (count !== 0)      begin n_fail++; $display("FAIL single_count_after actual=%0d expected=0", count); end
    n_checks++; if (mem_we !== 0)     begin n_fail++; $display("FAIL single_mem_we_after actual=%0b expected=0", mem_we); end
  endtask

  task automatic test_fill_stall();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memwrite = 1'b1; dataadr = 80 + 4 * i; writedata = 100 + i;
      tick();
    end
    memwrite = 1'b0;
    #1;
    n_checks++; if (count !== 4) begin n_fail++; $display("FAIL fill_count actual=%0d expected=4", count); end
    memwrite = 1'b1; dataadr = 96; writedata = 200;
    #1;
    n_checks++; if (stall !== 1) begin n_fail++; $display("FAIL fill_stall actual=%0b expected=1", stall); end
    tick();
    n_checks++; if (count !== 4)     begin n_fail++; $display("FAIL fill_hold_count actual=%0d expected=4", count); end
    n_checks++; if (mem_addr !== 80) begin n_fail++; $display("FAIL fill_hold_addr actual=%0d expected=80", mem_addr); end
    mem_ready = 1'b1;
    #1;
    n_checks++; if (stall !== 1) begin n_fail++; $display("FAIL fill_stall_on_pop actual=%0b expected=1", stall); end
    tick();
    n_checks++; if (count !== 3)     begin n_fail++; $display("FAIL fill_after_pop_count actual=%0d expected=3", count); end
    n_checks++; if (stall !== 0)     begin n_fail++; $display("FAIL fill_after_pop_stall actual=%0b expected=0", stall); end
    n_checks++; if (mem_addr !== 84) begin n_fail++; $display("FAIL fill_after_pop_addr actual=%0d expected=84", mem_addr); end
    tick();
    memwrite = 1'b0;
    #1;
    n_checks++; if (count !== 3)     begin n_fail++; $display("FAIL fill_accept_count actual=%0d expected=3", count); end
    for (int k = 0; k < 40 && count != 0; k++) tick();
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL fill_drain_timeout actual=%0d expected=0", count); end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    memwrite = 1'b1; dataadr = 'hA0; writedata = 1; tick();
    dataadr = 'hA4; writedata = 2; tick();
    dataadr = 'hA8; writedata = 3; mem_ready = 1'b1;
    #1;
    n_checks++; if (count !== 2)        begin n_fail++; $display("FAIL b2b_pre_count actual=%0d expected=2", count); end
    n_checks++; if (mem_addr !== 'hA0)  begin n_fail++; $display("FAIL b2b_pre_addr actual=%h expected=a0", mem_addr); end
    tick();
    memwrite = 1'b0; mem_ready = 1'b0;
    #1;
    n_checks++; if (count !== 2)        begin n_fail++; $display("FAIL b2b_count actual=%0d expected=2", count); end
    n_checks++; if (mem_addr !== 'hA4)  begin n_fail++; $display("FAIL b2b_head actual=%h expected=a4", mem_addr); end
    mem_ready = 1'b1;
    for (int k = 0; k < 40 && count != 0; k++) tick();
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL b2b_drain_timeout actual=%0d expected=0", count); end
  endtask

  task automatic test_forward();
    logic          eh;
    logic [DW-1:0] ed;
    eh = FWD;
    ed = FWD ? 9 : 0;
    mem_ready = 1'b0;
    memwrite = 1'b1; dataadr = 80;    writedata = 5; tick();
    dataadr = 80;    writedata = 9; tick();
    dataadr = 'h100; writedata = 3; tick();
    memwrite = 1'b0; rd_addr = 82;
    #1;
    n_checks++; if (fwd_hit !== eh)  begin n_fail++; $display("FAIL fwd_hit actual=%0b expected=%0b", fwd_hit, eh); end
    n_checks++; if (fwd_data !== ed) begin n_fail++; $display("FAIL fwd_data actual=%0d expected=%0d", fwd_data, ed); end
    rd_addr = 'h200;
    #1;
    n_checks++; if (fwd_hit !== 0)   begin n_fail++; $display("FAIL fwd_miss_hit actual=%0b expected=0", fwd_hit); end
    n_checks++; if (fwd_data !== 0)  begin n_fail++; $display("FAIL fwd_miss_data actual=%0d expected=0", fwd_data); end
    rd_addr = 80; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (fwd_hit !== eh)  begin n_fail++; $display("FAIL fwd_pop1_hit actual=%0b expected=%0b", fwd_hit, eh); end
    n_checks++; if (fwd_data !== ed) begin n_fail++; $display("FAIL fwd_pop1_data actual=%0d expected=%0d", fwd_data, ed); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (fwd_hit !== 0)   begin n_fail++; $display("FAIL fwd_pop2_hit actual=%0b expected=0", fwd_hit); end
    n_checks++; if (fwd_data !== 0)  begin n_fail++; $display("FAIL fwd_pop2_data actual=%0d expected=0", fwd_data); end
    mem_ready = 1'b1;
    for (int k = 0; k < 40 && count != 0; k++) tick();
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL fwd_drain_timeout actual=%0d expected=0", count); end
  endtask

  task automatic test_async_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      memwrite = 1'b1; dataadr = 'h300 + 4 * i; writedata = 50 + i;
      tick();
    end
    memwrite = 1'b0;
    #1;
    n_checks++; if (count !== 3) begin n_fail++; $display("FAIL arst_pre_count actual=%0d expected=3", count); end
    reset = 1'b0; memwrite = 1'b1; rd_addr = 'h300;
    #1;
    n_checks++; if (count !== 0)   begin n_fail++; $display("FAIL arst_count actual=%0d expected=0", count); end
    n_checks++; if (mem_we !== 0)  begin n_fail++; $display("FAIL arst_mem_we actual=%0b expected=0", mem_we); end
    n_checks++; if (stall !== 0)   begin n_fail++; $display("FAIL arst_stall actual=%0b expected=0", stall); end
    n_checks++; if (fwd_hit !== 0) begin n_fail++; $display("FAIL arst_fwd_hit actual=%0b expected=0", fwd_hit); end
    memwrite = 1'b0;
    tick();
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (mem_we !== 0) begin n_fail++; $display("FAIL arst_stale actual=%0b expected=0", mem_we); end
    end
  endtask

  task automatic test_wrap();
    int base;
    base = pops;
    mem_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      memwrite = 1'b1; dataadr = 'h1000 + 4 * i; writedata = $urandom;
      #1;
      n_checks++; if (stall !== 0) begin n_fail++; $display("FAIL wrap_stall actual=%0b expected=0 at %0d", stall, i); end
      tick();
    end
    memwrite = 1'b0;
    for (int k = 0; k < 40 && count != 0; k++) tick();
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL wrap_drain_timeout actual=%0d expected=0", count); end
    n_checks++;
    if (pops - base != 2 * DEPTH + 1) begin
      n_fail++;
      $display("FAIL wrap_pop_total actual=%0d expected=%0d", pops - base, 2 * DEPTH + 1);
    end
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    mem_ready = 1'b0; rd_addr = '0;
    test_reset();
    test_single();
    test_fill_stall();
    test_back_to_back();
    test_forward();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of buffered stores (power of two, 2..16).
REQ-003 Parameter AW, default 32, SHALL set the address width.
REQ-004 Parameter DW, default 32, SHALL set the data width.
REQ-005 clk  input  1  SHALL be the sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous active-low reset.
REQ-007 memwrite  input  1  SHALL be the CPU store strobe.
REQ-008 dataadr  input  AW  SHALL be the CPU store address.
REQ-009 writedata  input  DW  SHALL be the CPU store data.
REQ-010 stall  output  1  SHALL tell the CPU to hold its current store.
REQ-011 mem_we  output  1  SHALL be the valid strobe toward data memory.
REQ-012 mem_addr  output  AW  SHALL be the head-entry address.
REQ-013 mem_wdata  output  DW  SHALL be the head-entry data.
REQ-014 mem_ready  input  1  SHALL be the data-memory accept signal.
REQ-015 rd_addr  input  AW  SHALL be the CPU load address for forwarding lookup.
REQ-016 fwd_hit  output  1  SHALL flag a buffered store matching rd_addr.
REQ-017 fwd_data  output  DW  SHALL be the forwarded store data.
REQ-018 count  output  $clog2(DEPTH)+1  SHALL be the current occupancy.

Function
REQ-019 Storage SHALL be a circular FIFO: write pointer, read pointer, occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-020 Push SHALL occur on a rising edge when memwrite=1 and count<DEPTH; the entry holds {dataadr, writedata}.
REQ-021 stall SHALL be combinational: memwrite & (count==DEPTH); no push occurs while stall=1.
REQ-022 mem_we SHALL equal (count!=0); mem_addr/mem_wdata SHALL present the head entry, combinationally from storage.
REQ-023 Pop SHALL occur on a rising edge when mem_we=1 and mem_ready=1; head advances by one.
REQ-024 mem_addr/mem_wdata SHALL remain stable while mem_we=1 and mem_ready=0.
REQ-025 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-026 When count==DEPTH, a same-cycle pop SHALL NOT permit a push; stall stays asserted that cycle and the store is accepted the next cycle.
REQ-027 When count==0, mem_ready SHALL be ignored; a store pushed at edge N SHALL appear on mem_we after edge N (minimum latency one cycle).
REQ-028 Stores SHALL drain in strict program order; no coalescing of same-address stores.
REQ-029 Address comparison for forwarding SHALL use rd_addr[AW-1:2] against entry address[AW-1:2] (word granularity).
REQ-030 With multiple matches, fwd_data SHALL come from the youngest valid entry; fwd_hit/fwd_data are combinational.
REQ-031 Forwarding SHALL consider only valid entries; an entry popped at an edge is not a match after that edge.

Reset
REQ-032 On reset low: pointers=0, count=0, mem_we=0, stall=0 (for any memwrite), fwd_hit=0, fwd_data=0.
REQ-033 Reset mid-drain SHALL discard all buffered stores immediately, without waiting for mem_ready.
REQ-034 Storage array contents SHALL NOT require reset; outputs derived from them SHALL be masked by validity.

Configuration
REQ-035 Macro STORE_BUFFER_FWD_EN defined: forwarding per REQ-029..031 is compiled in.
REQ-036 Macro STORE_BUFFER_FWD_EN undefined: comparators are omitted; fwd_hit tied 0, fwd_data tied 0; rd_addr unused.

Verification
REQ-037 Reset, then single store adr=84 data=7, mem_ready=1 -> mem_we=1 next cycle with mem_addr=84, mem_wdata=7; count returns 0 one edge later.
REQ-038 mem_ready=0, four stores adr=80,84,88,92 -> count=4; fifth store raises stall=1; release mem_ready -> drain order 80,84,88,92, fifth accepted after first pop.
REQ-039 count=2, memwrite=1 and mem_ready=1 same cycle -> count stays 2, head advances, new entry at tail.
REQ-040 Stores adr=80 data=5 then adr=80 data=9 buffered, rd_addr=80 -> fwd_hit=1, fwd_data=9 (with STORE_BUFFER_FWD_EN); fwd_hit=0 without.
REQ-041 count=3 with mem_ready=0, assert reset low -> mem_we=0, count=0 asynchronously; after release no stale store emitted.
REQ-042 Wrap test: 2*DEPTH+1 stores with continuous mem_ready=1 -> all data emitted in order, no stall, pointers wrap correctly.
